ps2_frame_receiver: RTL and testbench

- Sequences the scan-code parity check for the keyboard front end.
- Synchronises the PS/2 clock and data lines and shifts in 11-bit frames: start bit, 8 data bits LSB first, odd parity bit, stop bit.
- Runs the odd-parity check and presents validated scan codes through a one-entry valid/ready output register.
- Sits between the PS/2 pins and the scan-code consumer (command decoder / I2C bridge logic).

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_odd_parity.sv | 18 +
 rtl/ps2_frame_receiver.sv | 168 ++++++++++++++++
 tb/tb_ps2_frame_receiver.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared frame constants, FSM state encoding and parity helper
//            for the PS/2 scan-code receiver.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic ODD_PARITY      = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2State_e;

  // True when the data bits together with the parity bit hold an odd count of ones.
  function automatic logic oddParityOk(input logic [FRAME_DATA_BITS-1:0] data,
                                       input logic parityBit);
    return ((^data) ^ parityBit) == ODD_PARITY;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_odd_parity.sv
`default_nettype none
// ============================================================================
// Module   : ps2_odd_parity
// Brief    : Combinational odd-parity checker for one received scan code.
// Revision : 1.0
// ============================================================================
module ps2_odd_parity
  import ps2_pkg::*;
(
  input  logic [FRAME_DATA_BITS-1:0] data,
  input  logic                       parityBit,
  output logic                       parityOk
);

  assign parityOk = oddParityOk(data, parityBit);

endmodule
`default_nettype wire

// File: rtl/ps2_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ps2_frame_receiver
// Brief    : Synchronises the PS/2 pins, shifts in 11-bit frames, checks odd
//            parity and presents scan codes in a one-entry valid/ready register.
// Revision : 1.0
// ============================================================================
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] scanCode,
  output logic       scanValid,
  input  logic       scanReady,
  output logic       parityErr,
  output logic       frameErr,
  output logic       overrun,
  output logic       busy
);

  localparam logic [1:0] c_IDLE   = IDLE;
  localparam logic [1:0] c_DATA   = DATA;
  localparam logic [1:0] c_PARITY = PARITY;
  localparam logic [1:0] c_STOP   = STOP;

  localparam int                c_TO_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);
  localparam int                c_BIT_W    = $clog2(FRAME_DATA_BITS);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(FRAME_DATA_BITS - 1);

  logic [SYNC_STAGES-1:0]     r_clkSync;
  logic [SYNC_STAGES-1:0]     r_dataSync;
  logic                       r_clkPrev;
  logic [1:0]                 r_state;
  logic [c_BIT_W-1:0]         r_bitCnt;
  logic [c_TO_W-1:0]          r_toCnt;
  logic [FRAME_DATA_BITS-1:0] r_shiftReg;
  logic                       r_parityBit;
  logic [7:0]                 r_scanCode;
  logic                       r_scanValid;
  logic                       r_parityErr;
  logic                       r_frameErr;
  logic                       r_overrun;

  logic w_clkCur;
  logic w_data;
  logic w_event;
  logic w_timeout;
  logic w_stopEval;
  logic w_parityOk;
  logic w_load;

  assign w_clkCur  = r_clkSync[SYNC_STAGES-1];
  assign w_data    = r_dataSync[SYNC_STAGES-1];
  assign w_event   = r_clkPrev & ~w_clkCur;
  // A falling edge that coincides with the timeout still aborts the frame.
  assign w_timeout  = (r_state != c_IDLE) && (r_toCnt == c_TO_LAST);
  assign w_stopEval = w_event && !w_timeout && (r_state == c_STOP);
  assign w_load     = w_stopEval && w_data && w_parityOk && (!r_scanValid || scanReady);

  ps2_odd_parity u_parity (
    .data      (r_shiftReg),
    .parityBit (r_parityBit),
    .parityOk  (w_parityOk)
  );

  // Sync flops idle high so that reset itself never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clkSync  <= '1;
      r_dataSync <= '1;
      r_clkPrev  <= 1'b1;
    end else begin
      r_clkSync  <= {r_clkSync[SYNC_STAGES-2:0], ps2Clk};
      r_dataSync <= {r_dataSync[SYNC_STAGES-2:0], ps2Data};
      r_clkPrev  <= w_clkCur;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_toCnt <= '0;
    end else if ((r_state == c_IDLE) || w_event) begin
      r_toCnt <= '0;
    end else begin
      r_toCnt <= r_toCnt + c_TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_bitCnt    <= '0;
      r_shiftReg  <= '0;
      r_parityBit <= 1'b0;
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_parityErr <= 1'b0;
      r_frameErr  <= 1'b0;
      r_overrun   <= 1'b0;
      if (w_timeout) begin
        r_state    <= c_IDLE;
        r_frameErr <= 1'b1;
      end else if (w_event) begin
        case (r_state)
          c_IDLE: begin
            if (!w_data) begin
              r_state  <= c_DATA;
              r_bitCnt <= '0;
            end
          end
          c_DATA: begin
            r_shiftReg <= {w_data, r_shiftReg[FRAME_DATA_BITS-1:1]};
            r_bitCnt   <= r_bitCnt + c_BIT_W'(1);
            if (r_bitCnt == c_BIT_LAST) begin
              r_state <= c_PARITY;
            end
          end
          c_PARITY: begin
            r_parityBit <= w_data;
            r_state     <= c_STOP;
          end
          c_STOP: begin
            r_state <= c_IDLE;
            if (!w_data) begin
              r_frameErr <= 1'b1;
            end else if (!w_parityOk) begin
              r_parityErr <= 1'b1;
            end else if (r_scanValid && !scanReady) begin
              r_overrun <= 1'b1;
            end
          end
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

  // A load in the same cycle as a handshake keeps the register full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scanCode  <= 8'h00;
      r_scanValid <= 1'b0;
    end else if (w_load) begin
      r_scanCode  <= r_shiftReg;
      r_scanValid <= 1'b1;
    end else if (r_scanValid && scanReady) begin
      r_scanValid <= 1'b0;
    end
  end

  assign scanCode  = r_scanCode;
  assign scanValid = r_scanValid;
  assign parityErr = r_parityErr;
  assign frameErr  = r_frameErr;
  assign overrun   = r_overrun;
  assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_frame_receiver
// Brief    : Scoreboard bench: PS/2 frames in, consumed codes and error
//            pulses compared against an occupancy-level reference model.
// Revision : 1.0
// ============================================================================
module tb_ps2_frame_receiver;

  localparam int TB_TIMEOUT = 200;
  localparam int TB_SYNC    = 2;
  localparam int HALF       = 10;
  localparam int ERR_PAR    = 1;
  localparam int ERR_FRM    = 2;
  localparam int ERR_OVR    = 3;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       ps2Clk    = 1'b1;
  logic       ps2Data   = 1'b1;
  logic       scanReady = 1'b0;
  logic [7:0] scanCode;
  logic       scanValid;
  logic       parityErr;
  logic       frameErr;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastFallCyc = 0;
  int lastFrameErrCyc = -1;
  logic [7:0] expCodes[$];
  int         expErrs[$];
  bit         occupied = 1'b0;

  ps2_frame_receiver #(
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .SYNC_STAGES    (TB_SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2Clk    (ps2Clk),
    .ps2Data   (ps2Data),
    .scanCode  (scanCode),
    .scanValid (scanValid),
    .scanReady (scanReady),
    .parityErr (parityErr),
    .frameErr  (frameErr),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endfunction

  function automatic void failNow(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: actual 0x%0h required nothing", name, act);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] makeBits(input logic [7:0] code, input bit badPar, input bit badStop);
    logic [10:0] b;
    b[0]   = 1'b0;
    b[8:1] = code;
    b[9]   = (~^code) ^ badPar;
    b[10]  = ~badStop;
    return b;
  endfunction

  task automatic sendBits(input logic [10:0] bits, input int nBits, input bit pulseOnStop);
    for (int i = 0; i < nBits; i++) begin
      ps2Data = bits[i];
      repeat (HALF) tick();
      ps2Clk = 1'b0;
      lastFallCyc = cyc;
      if (pulseOnStop && i == 10) begin
        // Ready lands exactly in the cycle the synchronised stop edge is seen.
        repeat (TB_SYNC) tick();
        scanReady = 1'b1;
        tick();
        scanReady = 1'b0;
        repeat (HALF - TB_SYNC - 1) tick();
      end else begin
        repeat (HALF) tick();
      end
      ps2Clk = 1'b1;
    end
    ps2Data = 1'b1;
  endtask

  // Reference model: frame outcome from stop/parity rules and register occupancy.
  task automatic frame(input logic [7:0] code, input bit badPar, input bit badStop, input bit pulse);
    bit consumedNow;
    consumedNow = scanReady || pulse;
    if (badStop || badPar) begin
      expErrs.push_back(badStop ? ERR_FRM : ERR_PAR);
      if (consumedNow) occupied = 1'b0;
    end else if (occupied && !consumedNow) begin
      expErrs.push_back(ERR_OVR);
    end else begin
      expCodes.push_back(code);
      occupied = !scanReady;
    end
    sendBits(makeBits(code, badPar, badStop), 11, pulse);
    repeat (8) tick();
  endtask

  task automatic drain();
    scanReady = 1'b1;
    repeat (2) tick();
    scanReady = 1'b0;
    occupied  = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_scanCode"},  scanCode,  8'h00);
    check({tag, "_scanValid"}, scanValid, 1'b0);
    check({tag, "_parityErr"}, parityErr, 1'b0);
    check({tag, "_frameErr"},  frameErr,  1'b0);
    check({tag, "_overrun"},   overrun,   1'b0);
    check({tag, "_busy"},      busy,      1'b0);
  endtask

  // Monitor: pops expectations whenever the DUT pulses an error or hands off a code.
  logic       prevHeld = 1'b0;
  logic [7:0] prevCode = 8'h00;
  always @(negedge clk) begin : mon
    int n;
    int kind;
    if (rst_n) begin
      n = 0;
      if (parityErr) n++;
      if (frameErr)  n++;
      if (overrun)   n++;
      if (n > 1) check("pulse_exclusive", n, 1);
      if (n > 0) begin
        kind = parityErr ? ERR_PAR : (frameErr ? ERR_FRM : ERR_OVR);
        if (frameErr) lastFrameErrCyc = cyc;
        if (expErrs.size() == 0) failNow("unexpected_err_pulse", kind);
        else check("err_kind", kind, expErrs.pop_front());
      end
      if (prevHeld && scanValid) check("code_stable", scanCode, prevCode);
      if (scanValid && scanReady) begin
        if (expCodes.size() == 0) failNow("unexpected_consume", scanCode);
        else check("consumed_code", scanCode, expCodes.pop_front());
      end
      prevHeld = scanValid && !scanReady;
      prevCode = scanCode;
    end else begin
      prevHeld = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    checkResetOutputs("reset");
    rst_n = 1'b1;
    tick();

    frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check("badpar_valid", scanValid, 1'b0);
    check("badpar_code",  scanCode,  8'h00);

    frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("t1_valid", scanValid, 1'b1);
    check("t1_code",  scanCode,  8'h1C);
    repeat (100) tick();
    check("t1_hold_valid", scanValid, 1'b1);
    check("t1_hold_code",  scanCode,  8'h1C);
    scanReady = 1'b1;
    tick();
    scanReady = 1'b0;
    occupied  = 1'b0;
    check("t1_valid_clear", scanValid, 1'b0);

    frame(8'hF0, 1'b0, 1'b0, 1'b0);
    frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("ovr_code_kept", scanCode,  8'hF0);
    check("ovr_valid",     scanValid, 1'b1);
    frame(8'h5A, 1'b0, 1'b0, 1'b1);
    check("swap_valid", scanValid, 1'b1);
    check("swap_code",  scanCode,  8'h5A);
    drain();

    frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("badstop_valid", scanValid, 1'b0);
    frame(8'h29, 1'b0, 1'b0, 1'b0);
    check("after_badstop_code", scanCode, 8'h29);
    drain();

    expErrs.push_back(ERR_FRM);
    sendBits(makeBits(8'h1C, 1'b0, 1'b0), 6, 1'b0);
    check("partial_busy", busy, 1'b1);
    repeat (TB_TIMEOUT + 20) tick();
    // Counter limit, plus synchroniser delay, edge-detect cycle and registered pulse.
    check("timeout_latency", lastFrameErrCyc - lastFallCyc, TB_TIMEOUT - 1 + TB_SYNC + 2);
    check("timeout_busy", busy, 1'b0);
    frame(8'h1C, 1'b0, 1'b0, 1'b0);
    check("after_timeout_code", scanCode, 8'h1C);

    sendBits(makeBits(8'h76, 1'b0, 1'b0), 4, 1'b0);
    check("midframe_busy", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expCodes.delete();
    expErrs.delete();
    occupied = 1'b0;
    checkResetOutputs("midreset");
    frame(8'h76, 1'b0, 1'b0, 1'b0);
    check("after_reset_code", scanCode, 8'h76);
    drain();

    for (int i = 0; i < 40; i++) begin
      logic [7:0] code;
      bit bp;
      bit bs;
      bit pl;
      code      = 8'($urandom);
      bp        = ($urandom_range(0, 5) == 0);
      bs        = ($urandom_range(0, 7) == 0);
      scanReady = 1'($urandom_range(0, 1));
      pl        = !scanReady && ($urandom_range(0, 3) == 0);
      frame(code, bp, bs, pl);
      if ($urandom_range(0, 2) == 0) drain();
    end

    scanReady = 1'b0;
    repeat (20) tick();
    drain();
    repeat (5) tick();
    check("codes_all_consumed", expCodes.size(), 0);
    check("errs_all_seen",      expErrs.size(),  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
